// File: rtl/mem_interface_wrapped_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface_wrapped_pkg
// Description : Shared widths, token typedefs and helpers for the dataflow
//               dual-port memory node.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_interface_wrapped_pkg;

    localparam int ADDR_LENGTH      = 5;
    localparam int MEM_ENTRY_LENGTH = 16;

    // Token buses: valid flag in the MSB, payload below it.
    typedef logic [ADDR_LENGTH:0]      addr_tok_t;
    typedef logic [MEM_ENTRY_LENGTH:0] data_tok_t;
    typedef logic [1:0]                wren_tok_t;

    // Two ready ports touching the same word collide unless both only read.
    function automatic logic addr_conflict(
        input logic                   req1,
        input logic                   req2,
        input logic [ADDR_LENGTH-1:0] a1,
        input logic [ADDR_LENGTH-1:0] a2,
        input logic                   we1,
        input logic                   we2
    );
        return req1 & req2 & (a1 == a2) & (we1 | we2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_interface_wrapped_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : One request port of the memory node: three operand slots
//               (addr, data, wren), their backpressure, the fire decision
//               and the result token register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl
    import mem_interface_wrapped_pkg::*;
#(
    parameter int AW = ADDR_LENGTH,
    parameter int DW = MEM_ENTRY_LENGTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW:0]   i_addr,
    output logic          o_addr_stop,
    input  logic [DW:0]   i_data,
    output logic          o_data_stop,
    input  logic [1:0]    i_wren,
    output logic          o_wren_stop,
    input  logic          i_down_stop,
    input  logic          i_stall,
    input  logic [DW-1:0] i_rd_data,
    output logic          o_req,
    output logic          o_fire,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_we,
    output logic [DW:0]   o_result
);

    logic          r_addr_full;
    logic          r_data_full;
    logic          r_wren_full;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_we;
    logic [DW:0]   r_result;

    logic          w_addr_acc;
    logic          w_data_acc;
    logic          w_wren_acc;
    logic [DW-1:0] w_result;

    // The port is ready when every operand is present and the result slot
    // is free or being drained this cycle; a conflict stall can veto it.
    assign o_req  = r_addr_full & r_data_full & r_wren_full
                  & (~r_result[DW] | ~i_down_stop);
    assign o_fire = o_req & ~i_stall;

    // A full slot only refuses a token when it is not being emptied.
    assign o_addr_stop = r_addr_full & ~o_fire;
    assign o_data_stop = r_data_full & ~o_fire;
    assign o_wren_stop = r_wren_full & ~o_fire;

    assign w_addr_acc = i_addr[AW] & ~o_addr_stop;
    assign w_data_acc = i_data[DW] & ~o_data_stop;
    assign w_wren_acc = i_wren[1]  & ~o_wren_stop;

    // Writes echo the stored data; reads return the pre-edge memory word.
    assign w_result = r_we ? r_data : i_rd_data;

    assign o_addr    = r_addr;
    assign o_wr_data = r_data;
    assign o_we      = r_we;
    assign o_result  = r_result;

    // Operand slots: accept a new token, otherwise clear on fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_full <= 1'b0;
            r_data_full <= 1'b0;
            r_wren_full <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
        end else begin
            if (w_addr_acc) begin
                r_addr_full <= 1'b1;
                r_addr      <= i_addr[AW-1:0];
            end else if (o_fire) begin
                r_addr_full <= 1'b0;
            end
            if (w_data_acc) begin
                r_data_full <= 1'b1;
                r_data      <= i_data[DW-1:0];
            end else if (o_fire) begin
                r_data_full <= 1'b0;
            end
            if (w_wren_acc) begin
                r_wren_full <= 1'b1;
                r_we        <= i_wren[0];
            end else if (o_fire) begin
                r_wren_full <= 1'b0;
            end
        end
    end

    // Result token: load on fire, hold under backpressure, else drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (o_fire) begin
            r_result <= {1'b1, w_result};
        end else if (!i_down_stop) begin
            r_result[DW] <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_interface_wrapped.sv
`default_nettype none
// ============================================================================
// Module      : mem_interface_wrapped
// Description : Dual-port token-based memory node. Holds the register array,
//               the same-address conflict stall (port 1 wins) and the write
//               path; each port's handshake lives in mem_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_interface_wrapped #(
    parameter int ADDR_LENGTH      = 5,
    parameter int MEM_ENTRY_LENGTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_LENGTH:0]      addr1,
    output logic                      addr1_stop,
    input  logic [MEM_ENTRY_LENGTH:0] in_data1,
    output logic                      in_data1_stop,
    input  logic [1:0]                wren1,
    output logic                      wren1_stop,
    output logic [MEM_ENTRY_LENGTH:0] out_data1,
    input  logic                      down_stop1,
    input  logic [ADDR_LENGTH:0]      addr2,
    output logic                      addr2_stop,
    input  logic [MEM_ENTRY_LENGTH:0] in_data2,
    output logic                      in_data2_stop,
    input  logic [1:0]                wren2,
    output logic                      wren2_stop,
    output logic [MEM_ENTRY_LENGTH:0] out_data2,
    input  logic                      down_stop2
);
    import mem_interface_wrapped_pkg::*;

    localparam int c_DEPTH = 1 << ADDR_LENGTH;

    logic [MEM_ENTRY_LENGTH-1:0] r_mem [c_DEPTH];

    logic                        w_req1, w_req2;
    logic                        w_fire1, w_fire2;
    logic [ADDR_LENGTH-1:0]      w_addr1, w_addr2;
    logic [MEM_ENTRY_LENGTH-1:0] w_wdata1, w_wdata2;
    logic                        w_we1, w_we2;
    logic                        w_stall2;

    // Port 2 yields for one cycle when both ports touch the same word and
    // at least one of them writes.
    assign w_stall2 = addr_conflict(w_req1, w_req2, w_addr1, w_addr2, w_we1, w_we2);

    mem_port_ctrl #(
        .AW (ADDR_LENGTH),
        .DW (MEM_ENTRY_LENGTH)
    ) u_port1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (addr1),
        .o_addr_stop (addr1_stop),
        .i_data      (in_data1),
        .o_data_stop (in_data1_stop),
        .i_wren      (wren1),
        .o_wren_stop (wren1_stop),
        .i_down_stop (down_stop1),
        .i_stall     (1'b0),
        .i_rd_data   (r_mem[w_addr1]),
        .o_req       (w_req1),
        .o_fire      (w_fire1),
        .o_addr      (w_addr1),
        .o_wr_data   (w_wdata1),
        .o_we        (w_we1),
        .o_result    (out_data1)
    );

    mem_port_ctrl #(
        .AW (ADDR_LENGTH),
        .DW (MEM_ENTRY_LENGTH)
    ) u_port2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (addr2),
        .o_addr_stop (addr2_stop),
        .i_data      (in_data2),
        .o_data_stop (in_data2_stop),
        .i_wren      (wren2),
        .o_wren_stop (wren2_stop),
        .i_down_stop (down_stop2),
        .i_stall     (w_stall2),
        .i_rd_data   (r_mem[w_addr2]),
        .o_req       (w_req2),
        .o_fire      (w_fire2),
        .o_addr      (w_addr2),
        .o_wr_data   (w_wdata2),
        .o_we        (w_we2),
        .o_result    (out_data2)
    );

    // Memory array: cleared by reset, written by whichever ports fire a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_fire1 && w_we1) begin
                r_mem[w_addr1] <= w_wdata1;
            end
            if (w_fire2 && w_we2) begin
                r_mem[w_addr2] <= w_wdata2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_interface_wrapped.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_interface_wrapped
// Description : Self-checking bench for mem_interface_wrapped with a
//               reference memory and per-port expected-result queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_interface_wrapped;
    import mem_interface_wrapped_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    addr_tok_t addr1, addr2;
    data_tok_t in_data1, in_data2;
    wren_tok_t wren1, wren2;
    logic      down_stop1, down_stop2;
    logic      addr1_stop, in_data1_stop, wren1_stop;
    logic      addr2_stop, in_data2_stop, wren2_stop;
    data_tok_t out_data1, out_data2;

    mem_interface_wrapped #(
        .ADDR_LENGTH      (ADDR_LENGTH),
        .MEM_ENTRY_LENGTH (MEM_ENTRY_LENGTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr1         (addr1),
        .addr1_stop    (addr1_stop),
        .in_data1      (in_data1),
        .in_data1_stop (in_data1_stop),
        .wren1         (wren1),
        .wren1_stop    (wren1_stop),
        .out_data1     (out_data1),
        .down_stop1    (down_stop1),
        .addr2         (addr2),
        .addr2_stop    (addr2_stop),
        .in_data2      (in_data2),
        .in_data2_stop (in_data2_stop),
        .wren2         (wren2),
        .wren2_stop    (wren2_stop),
        .out_data2     (out_data2),
        .down_stop2    (down_stop2)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    logic [15:0] model_mem [32];
    data_tok_t q1 [$];
    data_tok_t q2 [$];
    data_tok_t mon_e1, mon_e2;
    bit        addr_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: compute the result token now, in issue order.
    task automatic expect_op(input int port, input logic [4:0] a, input logic [15:0] d, input logic we);
        logic [15:0] r;
        r = we ? d : model_mem[a];
        if (we) model_mem[a] = d;
        if (port == 1) q1.push_back({1'b1, r});
        else           q2.push_back({1'b1, r});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present the selected tokens together and hold each until it transfers.
    task automatic drive(input int port, input bit use_a, input bit use_d, input bit use_w,
                         input logic [4:0] a, input logic [15:0] d, input logic we,
                         input bit nostop);
        bit pa, pd, pw;
        pa = use_a; pd = use_d; pw = use_w;
        if (port == 1) begin
            if (pa) addr1 = {1'b1, a};
            if (pd) in_data1 = {1'b1, d};
            if (pw) wren1 = {1'b1, we};
        end else begin
            if (pa) addr2 = {1'b1, a};
            if (pd) in_data2 = {1'b1, d};
            if (pw) wren2 = {1'b1, we};
        end
        for (int cyc = 0; cyc < 100 && (pa || pd || pw); cyc++) begin
            logic sa, sd, sw;
            @(negedge clk);
            sa = (port == 1) ? addr1_stop    : addr2_stop;
            sd = (port == 1) ? in_data1_stop : in_data2_stop;
            sw = (port == 1) ? wren1_stop    : wren2_stop;
            if (nostop && cyc == 0) begin
                if (pa) check("addr_stop_idle", {31'd0, sa}, 0);
                if (pd) check("data_stop_idle", {31'd0, sd}, 0);
                if (pw) check("wren_stop_idle", {31'd0, sw}, 0);
            end
            @(posedge clk);
            #1;
            if (pa && !sa) begin
                pa = 1'b0;
                if (port == 1) addr1 = '0; else addr2 = '0;
            end
            if (pd && !sd) begin
                pd = 1'b0;
                if (port == 1) in_data1 = '0; else in_data2 = '0;
            end
            if (pw && !sw) begin
                pw = 1'b0;
                if (port == 1) wren1 = '0; else wren2 = '0;
            end
        end
        check("drive_timeout", {29'd0, pa, pd, pw}, 0);
    endtask

    // Scoreboard: every consumed result token must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_data1[16] && !down_stop1) begin
                if (q1.size() == 0) begin
                    check("out1_unexpected", {15'd0, out_data1}, 0);
                end else begin
                    mon_e1 = q1.pop_front();
                    check("out1_result", {15'd0, out_data1}, {15'd0, mon_e1});
                end
            end
            if (out_data2[16] && !down_stop2) begin
                if (q2.size() == 0) begin
                    check("out2_unexpected", {15'd0, out_data2}, 0);
                end else begin
                    mon_e2 = q2.pop_front();
                    check("out2_result", {15'd0, out_data2}, {15'd0, mon_e2});
                end
            end
        end
    end

    initial begin
        addr1 = '0; addr2 = '0; in_data1 = '0; in_data2 = '0;
        wren1 = '0; wren2 = '0; down_stop1 = 1'b0; down_stop2 = 1'b0;
        rst_n = 1'b0;
        addr_done = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        cycles(2);
        check("rst_out1", {15'd0, out_data1}, 0);
        check("rst_out2", {15'd0, out_data2}, 0);
        check("rst_stops", {26'd0, addr1_stop, in_data1_stop, wren1_stop,
                            addr2_stop, in_data2_stop, wren2_stop}, 0);
        rst_n = 1'b1;
        cycles(1);

        // Port 1 write of 0xACDC to 22.
        expect_op(1, 5'd22, 16'hACDC, 1'b1);
        drive(1, 1, 1, 1, 5'd22, 16'hACDC, 1'b1, 1);
        @(negedge clk);
        check("wr_not_yet", {31'd0, out_data1[16]}, 0);
        @(negedge clk);
        check("wr_result", {15'd0, out_data1}, {15'd0, 1'b1, 16'hACDC});
        cycles(1);

        // Port 2 staggered read of 22.
        expect_op(2, 5'd22, 16'hACDC, 1'b0);
        drive(2, 1, 0, 0, 5'd22, 16'h0, 1'b0, 1);
        drive(2, 0, 1, 0, 5'd0, 16'hACDC, 1'b0, 1);
        cycles(3);
        check("stag_no_fire", {31'd0, out_data2[16]}, 0);
        drive(2, 0, 0, 1, 5'd0, 16'h0, 1'b0, 1);
        @(negedge clk);
        check("stag_not_yet", {31'd0, out_data2[16]}, 0);
        @(negedge clk);
        check("stag_result", {15'd0, out_data2}, {15'd0, 1'b1, 16'hACDC});
        cycles(1);

        // Backpressure on port 1.
        down_stop1 = 1'b1;
        expect_op(1, 5'd22, 16'h0, 1'b0);
        expect_op(1, 5'd3,  16'h0, 1'b0);
        expect_op(1, 5'd22, 16'h0, 1'b0);
        drive(1, 1, 1, 1, 5'd22, 16'h1234, 1'b0, 1);
        drive(1, 1, 1, 1, 5'd3,  16'h5678, 1'b0, 1);
        fork
            begin
                drive(1, 1, 0, 0, 5'd22, 16'h0, 1'b0, 0);
                addr_done = 1'b1;
            end
        join_none
        @(negedge clk);
        check("bp_addr_stop", {31'd0, addr1_stop}, 1);
        check("bp_hold_a", {15'd0, out_data1}, {15'd0, 1'b1, 16'hACDC});
        @(negedge clk);
        check("bp_hold_b", {15'd0, out_data1}, {15'd0, 1'b1, 16'hACDC});
        @(posedge clk);
        #1;
        down_stop1 = 1'b0;
        drive(1, 0, 1, 1, 5'd0, 16'h9ABC, 1'b0, 0);
        for (int i = 0; i < 50 && !addr_done; i++) cycles(1);
        check("bp_addr_done", {31'd0, addr_done}, 1);
        cycles(4);

        // Same-address write conflict: port 1 first, port 2 a cycle later.
        expect_op(1, 5'd5, 16'h1111, 1'b1);
        expect_op(2, 5'd5, 16'h2222, 1'b1);
        fork
            drive(1, 1, 1, 1, 5'd5, 16'h1111, 1'b1, 1);
            drive(2, 1, 1, 1, 5'd5, 16'h2222, 1'b1, 1);
        join
        @(negedge clk);
        check("cf_stall_stop2", {31'd0, addr2_stop}, 1);
        check("cf_go_stop1", {31'd0, addr1_stop}, 0);
        @(negedge clk);
        check("cf_out1", {15'd0, out_data1}, {15'd0, 1'b1, 16'h1111});
        check("cf_out2_wait", {31'd0, out_data2[16]}, 0);
        @(negedge clk);
        check("cf_out2", {15'd0, out_data2}, {15'd0, 1'b1, 16'h2222});
        cycles(1);
        expect_op(1, 5'd5, 16'h0, 1'b0);
        drive(1, 1, 1, 1, 5'd5, 16'h0, 1'b0, 1);
        cycles(3);

        // Both ports read the same word together.
        expect_op(1, 5'd22, 16'h0, 1'b0);
        expect_op(2, 5'd22, 16'h0, 1'b0);
        fork
            drive(1, 1, 1, 1, 5'd22, 16'h0, 1'b0, 1);
            drive(2, 1, 1, 1, 5'd22, 16'h0, 1'b0, 1);
        join
        @(negedge clk);
        check("dual_rd_no_stall", {31'd0, addr2_stop}, 0);
        cycles(3);

        // Reset with a partially gathered operation.
        drive(1, 1, 1, 0, 5'd22, 16'hBEEF, 1'b0, 1);
        cycles(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out1", {15'd0, out_data1}, 0);
        check("mid_rst_out2", {15'd0, out_data2}, 0);
        check("mid_rst_stops", {26'd0, addr1_stop, in_data1_stop, wren1_stop,
                                addr2_stop, in_data2_stop, wren2_stop}, 0);
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        q1.delete();
        q2.delete();
        cycles(1);
        rst_n = 1'b1;
        cycles(1);
        drive(1, 0, 0, 1, 5'd0, 16'h0, 1'b0, 1);
        cycles(3);
        check("post_rst_no_fire", {31'd0, out_data1[16]}, 0);
        expect_op(1, 5'd22, 16'h5555, 1'b0);
        drive(1, 1, 1, 0, 5'd22, 16'h5555, 1'b0, 1);
        cycles(3);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) cycles(1);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
